adder_tree_sched: RTL and testbench
===================================

// Module: adder_tree_sched
// PURPOSE
//  Shares one 64-input adder tree (adder_tree_64) between N_REQ requesters.
//  Each job is a vector of LEN 64-element chunks; the block grants one requester round-robin,
//  streams its chunks through the tree, and accumulates the chunk sums into one scalar.
//  It returns that scalar to the granted requester. Sits between CNN conv/FC lanes and the reduction datapath.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  WIDTH   32  element/tree width, signed two's complement
//  ACC_W   48  accumulator/result width, signed (ACC_W >= WIDTH)
//  LEN_W   8   width of per-job chunk count
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  req        in   N_REQ           job request, one bit per requester; held until its result handshake
//  req_len    in   N_REQ*LEN_W     chunk count per requester, sampled at grant
//  gnt        out  N_REQ           one-hot grant, held from grant until result handshake
//  chunk_data in   N_REQ*64*WIDTH  per-requester chunk, element e of req r at [(r*64+e)*WIDTH +: WIDTH]
//  chunk_valid in  N_REQ           chunk present
//  chunk_ready out N_REQ           chunk accepted (only granted bit can be 1)
//  res_valid  out  1               result valid
//  res_data   out  ACC_W           accumulated sum
//  res_id     out  $clog2(N_REQ)   index of requester owning res_data
//  res_ready  in   1               result consumed
// BEHAVIOUR
//  Reset values: gnt=0, chunk_ready=0, res_valid=0, res_data=0, res_id=0; acc=0, rr_ptr=0, state=IDLE.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: if |req, pick first set bit at or after rr_ptr (wrapping); latch id, len=req_len[id];
//     clear acc; set gnt=onehot(id). If len==0 go DONE (result 0), else RUN. If no req, stay in IDLE.
//   RUN: chunk_ready[id]=1 (combinational from state, not from chunk_valid). On chunk_valid[id]&&chunk_ready[id]:
//     acc <= acc + sext(tree_sum), cnt++. Tree input is muxed from chunk_data of id.
//     The tree is combinational and wraps modulo 2^WIDTH. On the len-th handshake go to DONE.
//   DONE: res_valid=1, res_data=acc, res_id=id. On res_ready: gnt<=0, rr_ptr<=(id+1)%N_REQ, go to IDLE.
//  Latency: res_valid rises the cycle after the last chunk handshake.
//  Throughput: 1 chunk/cycle in RUN.
//  Job overhead: one IDLE arbitration cycle after each result handshake, so there is no same-cycle regrant.
//  Accumulator: chunk sum is sign-extended to ACC_W; acc wraps modulo 2^ACC_W with no saturation or flag.
//  Non-granted requesters: chunk_valid is ignored and chunk_ready=0; their req stays pending.
//  Dropping req mid-job is ignored: the job runs to completion on the latched len.
//  req_len changes after the grant have no effect.
//  chunk_valid low in RUN stalls: acc and cnt are held, with no timeout.
//  res_ready held low in DONE keeps res_valid, res_data and res_id stable.
//  Reset asserted in any state aborts the job: all state returns to reset values next cycle, and no partial result is emitted.
//  Starvation-free: a continuously asserted req is granted within N_REQ jobs.
// STRUCTURE
//  Package adder_tree_pkg holds:
//   - state enum {IDLE, RUN, DONE};
//   - localparam TREE_N=64;
//   - function sext_acc().
//  Sub-module rr_arbiter #(N) (req, ptr -> one-hot gnt, idx) is combinational and is used only in IDLE.
//  The existing adder_tree_64 #(WIDTH) is instantiated once with the muxed chunk.
//  The FSM, counter and accumulator stay in this module.
// TESTING
//  1. Single requester, len=3, elements all 1, 2, -1 per chunk:
//     -> res_data=64+128-64=128, res_id=0, res_valid 1 cycle after 3rd handshake.
//  2. req=4'b1111 held, rr_ptr=0, len=1 each:
//     -> grants in order 0,1,2,3,0; exactly one IDLE cycle between res handshake and the next gnt.
//  3. len=0 on requester 2:
//     -> gnt[2] for IDLE->DONE, res_data=0 with no chunk_ready; next grant goes to 3.
//  4. Stall test, len=4, chunk_valid toggled 1010..., res_ready low 5 cycles:
//     -> correct sum; result fields stable while res_ready is low.
//  5. Overflow, WIDTH=32, ACC_W=48, 64 elements of 32'h7FFFFFFF:
//     -> tree wraps to 32'hFFFFFFC0, acc = -64 after one chunk.
//  6. rst pulsed mid-RUN after 2 of 5 chunks:
//     -> next cycle gnt=0, res_valid=0, chunk_ready=0; the re-issued job gives a fresh, correct sum.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared state type, tree size and sign-extension helper for the adder tree scheduler
package adder_tree_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int TREE_N = 64;
  localparam int SEXT_W = 64;

  // Sign-extend the low w bits of v across the full SEXT_W-bit word.
  function automatic logic [SEXT_W-1:0] sext_acc(input logic [SEXT_W-1:0] v, input int w);
    logic [SEXT_W-1:0] r;
    logic              sign;
    sign = 1'b0;
    for (int b = 0; b < SEXT_W; b++) begin
      if (b == w - 1) sign = v[b];
    end
    for (int b = 0; b < SEXT_W; b++) begin
      r[b] = (b < w) ? v[b] : sign;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_64.sv
// rtl/adder_tree_64.sv - combinational 64-input adder, result wraps modulo 2^WIDTH
module adder_tree_64
  import adder_tree_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [TREE_N*WIDTH-1:0] in,
  output logic [WIDTH-1:0]        sum
);

  // Plain wrapping sum of all elements; two's complement makes signedness irrelevant here.
  always_comb begin
    sum = '0;
    for (int e = 0; e < TREE_N; e++) begin
      sum = sum + in[e*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] pos;

  // Rotate requests so ptr sits at bit 0, find the lowest set bit, then map back with wrap.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W+1)'(i);
    end
    pos = {1'b0, ptr} + off;
    if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
    idx = pos[IDX_W-1:0];
    gnt = (|req) ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/adder_tree_sched.sv
// rtl/adder_tree_sched.sv - round-robin scheduler sharing one 64-input adder tree across requesters
module adder_tree_sched
  import adder_tree_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ACC_W = 48,
  parameter int LEN_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*LEN_W-1:0]           req_len,
  output logic [N_REQ-1:0]                 gnt,
  input  logic [N_REQ*TREE_N*WIDTH-1:0]    chunk_data,
  input  logic [N_REQ-1:0]                 chunk_valid,
  output logic [N_REQ-1:0]                 chunk_ready,
  output logic                             res_valid,
  output logic [ACC_W-1:0]                 res_data,
  output logic [$clog2(N_REQ)-1:0]         res_id,
  input  logic                             res_ready
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t                    state;
  logic [IDX_W-1:0]          id;
  logic [IDX_W-1:0]          rr_ptr;
  logic [LEN_W-1:0]          len;
  logic [LEN_W-1:0]          cnt;
  logic [ACC_W-1:0]          acc;

  logic [N_REQ-1:0]          arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic [LEN_W-1:0]          arb_len;
  logic [TREE_N*WIDTH-1:0]   tree_in;
  logic [WIDTH-1:0]          tree_sum;
  logic [ACC_W-1:0]          chunk_ext;
  logic                      hs;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  adder_tree_64 #(.WIDTH(WIDTH)) u_tree (
    .in  (tree_in),
    .sum (tree_sum)
  );

  // Select the owner's chunk for the tree and the candidate's length for the grant decision.
  always_comb begin
    tree_in = '0;
    arb_len = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (id == IDX_W'(r))      tree_in = chunk_data[r*TREE_N*WIDTH +: TREE_N*WIDTH];
      if (arb_idx == IDX_W'(r)) arb_len = req_len[r*LEN_W +: LEN_W];
    end
  end

  assign chunk_ext   = ACC_W'(sext_acc(SEXT_W'(tree_sum), WIDTH));
  assign chunk_ready = (state == RUN) ? gnt : '0;
  assign hs          = |(chunk_valid & chunk_ready);
  assign res_data    = acc;
  assign res_id      = id;

  // Job FSM: arbitrate in IDLE, accumulate chunk sums in RUN, present the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      res_valid <= 1'b0;
      id        <= '0;
      rr_ptr    <= '0;
      len       <= '0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            id  <= arb_idx;
            len <= arb_len;
            cnt <= '0;
            acc <= '0;
            gnt <= arb_gnt;
            if (arb_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (hs) begin
            acc <= acc + chunk_ext;
            cnt <= cnt + LEN_W'(1);
            if (cnt == len - LEN_W'(1)) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            rr_ptr    <= (id == IDX_W'(N_REQ - 1)) ? '0 : id + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_sched.sv
// tb/tb_adder_tree_sched.sv - self-checking bench for adder_tree_sched with a behavioural reference model
module tb_adder_tree_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int ACC_W = 48;
  localparam int LEN_W = 8;
  localparam int IDX_W = 2;
  localparam logic [63:0] MASK = 64'h0000_FFFF_FFFF_FFFF;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [N_REQ-1:0]              req;
  logic [N_REQ*LEN_W-1:0]        req_len;
  logic [N_REQ-1:0]              gnt;
  logic [N_REQ*64*WIDTH-1:0]     chunk_data;
  logic [N_REQ-1:0]              chunk_valid;
  logic [N_REQ-1:0]              chunk_ready;
  logic                          res_valid;
  logic [ACC_W-1:0]              res_data;
  logic [IDX_W-1:0]              res_id;
  logic                          res_ready;

  always #5 clk = ~clk;

  adder_tree_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_len     (req_len),
    .gnt         (gnt),
    .chunk_data  (chunk_data),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id),
    .res_ready   (res_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: 0 = waiting for a request, 1 = taking chunks, 2 = holding a result
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_left  = 0;
  int          m_ptr   = 0;
  logic [63:0] m_sum   = '0;
  int          last_done;

  int          order[$];
  int          got, dl, did_rst;
  logic [WIDTH-1:0] t1v [3];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_len(input int r, input int l);
    req_len[r*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  // mode 0: constant v, 1: random, 2: small signed values, 3: max positive
  task automatic fill(input int r, input int mode, input logic [WIDTH-1:0] v);
    for (int e = 0; e < 64; e++) begin
      logic [WIDTH-1:0] x;
      case (mode)
        0:       x = v;
        1:       x = $urandom;
        2:       x = WIDTH'($urandom_range(15)) - 32'd8;
        default: x = 32'h7FFF_FFFF;
      endcase
      chunk_data[(r*64+e)*WIDTH +: WIDTH] = x;
    end
  endtask

  function automatic logic [63:0] chunk_sum(input int r);
    int s;
    s = 0;
    for (int e = 0; e < 64; e++) s += int'(chunk_data[(r*64+e)*WIDTH +: WIDTH]);
    return 64'(longint'(s));
  endfunction

  // Compare outputs against the model, advance the model across the coming edge, and move to the next negedge.
  task automatic step();
    logic [N_REQ-1:0] eg;
    #1;
    eg = (m_phase != 0) ? N_REQ'(1 << m_owner) : '0;
    check("gnt", 64'(gnt), 64'(eg));
    check("chunk_ready", 64'(chunk_ready), (m_phase == 1) ? 64'(eg) : 64'd0);
    check("res_valid", 64'(res_valid), (m_phase == 2) ? 64'd1 : 64'd0);
    if (m_phase == 2) begin
      check("res_data", 64'(res_data), m_sum);
      check("res_id", 64'(res_id), 64'(m_owner));
    end
    last_done = -1;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_sum = '0; m_owner = 0; m_left = 0;
    end else begin
      case (m_phase)
        0: begin
          for (int i = 0; i < N_REQ; i++) begin
            int c;
            c = (m_ptr + i) % N_REQ;
            if (req[c]) begin
              m_owner = c;
              m_left  = int'(req_len[c*LEN_W +: LEN_W]);
              m_sum   = '0;
              m_phase = (m_left == 0) ? 2 : 1;
              break;
            end
          end
        end
        1: begin
          if (chunk_valid[m_owner]) begin
            m_sum = (m_sum + chunk_sum(m_owner)) & MASK;
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
        end
        default: begin
          if (res_ready) begin
            last_done = m_owner;
            m_ptr     = (m_owner + 1) % N_REQ;
            m_phase   = 0;
          end
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; chunk_valid = '0; res_ready = 1'b0;
    step();
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && m_phase != 0; c++) begin
      res_ready = 1'b1;
      step();
    end
    check("drain_idle", 64'(m_phase), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_len = '0; chunk_data = '0; chunk_valid = '0; res_ready = 1'b0;
    t1v[0] = 32'd1; t1v[1] = 32'd2; t1v[2] = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // single requester, three chunks of 1, 2, -1
    req = 4'b0001; set_len(0, 3); chunk_valid = '1; res_ready = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_phase == 1) fill(0, 0, t1v[3 - m_left]);
      if (m_phase == 2) begin
        check("t1_sum", 64'(res_data), 64'd128);
        check("t1_id", 64'(res_id), 64'd0);
      end
      step();
      if (last_done == 0) begin req[0] = 1'b0; got = 1; break; end
    end
    check("t1_done", 64'(got), 64'd1);

    // all requesters held, one chunk each: strict rotation
    do_reset();
    req = '1; chunk_valid = '1; res_ready = 1'b1;
    for (int r = 0; r < N_REQ; r++) set_len(r, 1);
    order.delete();
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      for (int r = 0; r < N_REQ; r++) fill(r, 1, '0);
      step();
      if (last_done >= 0) order.push_back(last_done);
    end
    req = '0;
    check("t2_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) check("t2_order", 64'(order[i]), 64'(i % N_REQ));
    drain();

    // zero-length job on requester 2, then requester 3
    req = 4'b1100; set_len(2, 0); set_len(3, 1); fill(3, 2, '0); order.delete();
    for (int c = 0; c < 30 && order.size() < 2; c++) begin
      if (m_phase == 2 && m_owner == 2) check("t3_zero", 64'(res_data), 64'd0);
      step();
      if (last_done >= 0) begin order.push_back(last_done); req[last_done] = 1'b0; end
    end
    check("t3_count", 64'(order.size()), 64'd2);
    if (order.size() == 2) begin
      check("t3_first", 64'(order[0]), 64'd2);
      check("t3_second", 64'(order[1]), 64'd3);
    end

    // stalled chunks, late result consumer, length changed after grant
    req = 4'b0010; set_len(1, 4); dl = 0; got = 0;
    for (int c = 0; c < 60; c++) begin
      chunk_valid = (c % 2 == 0) ? '1 : '0;
      fill(1, 1, '0);
      if (m_phase != 0) set_len(1, $urandom_range(9));
      res_ready = (m_phase == 2 && dl < 5) ? 1'b0 : 1'b1;
      if (m_phase == 2) dl++;
      step();
      if (last_done == 1) begin req[1] = 1'b0; got = 1; break; end
    end
    check("t4_done", 64'(got), 64'd1);
    check("t4_held", 64'(dl), 64'd6);

    // tree overflow wraps to -64
    req = 4'b0001; set_len(0, 1); fill(0, 3, '0); chunk_valid = '1; res_ready = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_phase == 2) check("t5_wrap", 64'(res_data), 64'h0000_FFFF_FFFF_FFC0);
      step();
      if (last_done == 0) begin req[0] = 1'b0; got = 1; break; end
    end
    check("t5_done", 64'(got), 64'd1);

    // reset in the middle of a job, then the job is re-issued
    req = 4'b1000; set_len(3, 5); fill(3, 0, 32'd1); chunk_valid = '1; res_ready = 1'b1;
    got = 0; did_rst = 0;
    for (int c = 0; c < 40; c++) begin
      if (!did_rst && m_phase == 1 && m_left == 3) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        did_rst = 1;
        check("t6_gnt", 64'(gnt), 64'd0);
        check("t6_ready", 64'(chunk_ready), 64'd0);
        check("t6_valid", 64'(res_valid), 64'd0);
        continue;
      end
      if (m_phase == 2) check("t6_sum", 64'(res_data), 64'd320);
      step();
      if (last_done == 3) begin req[3] = 1'b0; got = 1; break; end
    end
    check("t6_done", 64'(got && did_rst), 64'd1);

    // randomized traffic
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (!req[r] && $urandom_range(3) == 0) begin
          req[r] = 1'b1;
          set_len(r, $urandom_range(5));
        end
        fill(r, $urandom_range(3), $urandom);
      end
      chunk_valid = N_REQ'($urandom);
      res_ready   = ($urandom_range(3) != 0);
      if (m_phase != 0 && $urandom_range(7) == 0) set_len(m_owner, $urandom_range(9));
      if (m_phase == 1 && $urandom_range(15) == 0) req[m_owner] = 1'b0;
      rst = ($urandom_range(499) == 0);
      step();
      if (last_done >= 0) req[last_done] = 1'b0;
    end
    rst = 1'b0;
    req = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
